// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types. The fetch stage adds its FSM state and
// FIFO entry layout here so the decoder side can reuse them.
package cpu_pkg;

    // Raw instruction word; all zeros decodes as NONE/NOP.
    typedef logic [31:0] ir_t;

    localparam ir_t IR_NOP = 32'h0000_0000;

    // Fetch FSM states: nothing outstanding, read kept, read discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [15:0] pc;
        ir_t         ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small in-order FIFO of fetch_entry_t between the fetch
// FSM and the decoder. DEPTH must be a power of two so the pointers
// wrap naturally. A synchronous flush clears count and pointers.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    fetch_entry_t  slot_q [DEPTH];

    // Pointer and occupancy update; a flush overrides any push or pop.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates its visibility, so stale contents never escape.
        if (push && !flush) slot_q[wr_ptr_q] <= push_data;
    end

    assign head  = slot_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues one word read at a time,
// queues returned words with their address, and hands them to the
// decoder over ir_valid/ir_ready. A jump flushes the queue, redirects
// the PC and discards any read still in flight.
// Build option: define FETCH_BYPASS_EN to forward read data straight
// to ir when the queue is empty (zero-cycle rvalid-to-decode latency).
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rd_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output ir_t         ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        jump_en,
    input  logic [15:0] jump_addr
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   req_pc_q, req_pc_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_wdata;

    // State, fetch PC and request PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Next state and PC: a grant starts a read, rvalid retires it, a jump redirects.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            IDLE: begin
                if (mem_rd_req && mem_rd_gnt) begin
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 16'd1;
                end
            end
            WAIT: begin
                if (mem_rvalid)   state_d = IDLE;
                else if (jump_en) state_d = DROP;
            end
            DROP: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Request is gated off during a jump, so this never races the increment.
        if (jump_en) fetch_pc_d = jump_addr;
    end

    // Outputs: issue gating, queue push/pop and the decoder-facing head.
    always_comb begin
        mem_rd_req = (state_q == IDLE) && (fifo_count < DEPTH_C) && !jump_en && rst_n;
        mem_addr   = fetch_pc_q;

        fifo_wdata.pc = req_pc_q;
        fifo_wdata.ir = mem_rdata;
        fifo_push     = (state_q == WAIT) && mem_rvalid && !jump_en;

        ir_valid = !fifo_empty;
        ir       = fifo_empty ? IR_NOP : fifo_head.ir;
        ir_pc    = fifo_empty ? 16'h0000 : fifo_head.pc;
`ifdef FETCH_BYPASS_EN
        // Empty queue: show the returning word now and skip the queue if taken.
        if (fifo_empty && fifo_push) begin
            ir_valid = 1'b1;
            ir       = mem_rdata;
            ir_pc    = req_pc_q;
            if (ir_ready) fifo_push = 1'b0;
        end
`endif
        fifo_pop = !fifo_empty && ir_ready;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (jump_en),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a
// behavioural memory and an expected-entry scoreboard.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_rd_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    ir_t         ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump_en;
    logic [15:0] jump_addr;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_rd_gnt (mem_rd_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state
    logic        gnt_en = 1'b1;
    int          lat = 1;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_pend_addr = '0;

    // Scoreboard / reference state
    fetch_entry_t sb_q[$];
    logic [15:0]  grants[$];
    logic [15:0]  exp_pc = 16'h0100;
    logic         out_live = 1'b0;
    logic [15:0]  out_addr = '0;
    int           n_grants = 0;
    int           n_pops = 0;
    logic [15:0]  last_pop_pc = '0;
    logic         last_valid = 1'b0;
    logic         last_rvalid = 1'b0;
    logic         last_granted = 1'b0;
    logic         last_q_empty = 1'b0;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {4'h0, 8'h09, 4'h0, a};  // ADD-class word tagged with its address
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: starts and ends at a falling edge with inputs already set.
    task automatic cycle();
        logic         exp_req, granted, rv_live, bypass_now, exp_valid, popped;
        fetch_entry_t exp_head;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word_of(mem_pend_addr);
            end
        end
        mem_rd_gnt = gnt_en;
        #1;
        exp_req = !mem_pend && (sb_q.size() < DEPTH) && !jump_en;
        check("mem_rd_req", mem_rd_req, exp_req);
        granted = mem_rd_req && mem_rd_gnt;
        if (granted) begin
            check("mem_addr", mem_addr, exp_pc);
            grants.push_back(mem_addr);
            n_grants++;
        end
        rv_live    = mem_rvalid && out_live && !jump_en;
        bypass_now = BYP && rv_live && (sb_q.size() == 0);
        exp_valid  = (sb_q.size() != 0) || bypass_now;
        last_q_empty = (sb_q.size() == 0);
        check("ir_valid", ir_valid, exp_valid);
        popped = 1'b0;
        if (!exp_valid) begin
            check("ir_empty", ir, 32'h0);
            check("ir_pc_empty", ir_pc, 16'h0);
        end else begin
            if (bypass_now) begin
                exp_head.pc = out_addr;
                exp_head.ir = word_of(out_addr);
            end else begin
                exp_head = sb_q[0];
            end
            check("ir_pc", ir_pc, exp_head.pc);
            check("ir", ir, exp_head.ir);
            popped = ir_ready;
        end
        if (popped) begin
            n_pops++;
            last_pop_pc = exp_head.pc;
            if (!bypass_now) void'(sb_q.pop_front());
        end
        if (rv_live && !(bypass_now && popped)) begin
            check("push_not_full", sb_q.size() < DEPTH, 1'b1);
            exp_head.pc = out_addr;
            exp_head.ir = word_of(out_addr);
            sb_q.push_back(exp_head);
        end
        if (jump_en) begin
            sb_q.delete();
            exp_pc   = jump_addr;
            out_live = 1'b0;
        end
        if (mem_rvalid) begin
            mem_pend = 1'b0;
            out_live = 1'b0;
        end
        if (granted) begin
            exp_pc        = exp_pc + 16'd1;
            mem_pend      = 1'b1;
            mem_cnt       = lat;
            mem_pend_addr = mem_addr;
            out_live      = 1'b1;
            out_addr      = mem_addr;
        end
        last_valid   = ir_valid;
        last_rvalid  = mem_rvalid;
        last_granted = granted;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int  base;
        logic got;
        rst_n      = 1'b0;
        mem_rd_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        ir_ready   = 1'b0;
        jump_en    = 1'b0;
        jump_addr  = '0;

        // Reset values
        #2;
        check("rst_ir_valid", ir_valid, 1'b0);
        check("rst_ir", ir, 32'h0);
        check("rst_ir_pc", ir_pc, 16'h0);
        check("rst_mem_rd_req", mem_rd_req, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC with a 1-cycle memory
        ir_ready = 1'b1;
        lat      = 1;
        run(10);
        check("seq_addr0", grants[0], 16'h0100);
        check("seq_addr1", grants[1], 16'h0101);
        check("seq_addr2", grants[2], 16'h0102);
        check("seq_pop_seen", n_pops >= 3, 1'b1);

        // Decoder stalled: exactly DEPTH grants, then no more requests
        ir_ready  = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 16'h0200;
        cycle();
        jump_en = 1'b0;
        base = n_grants;
        run(10);
        check("stall_grants", n_grants - base, 2);
        check("stall_last_addr", grants[$], 16'h0201);
        ir_ready = 1'b1;
        cycle();
        ir_ready = 1'b0;
        base = n_grants;
        run(6);
        check("one_pop_one_req", n_grants - base, 1);

        // Jump while WAIT; stale data returns 3 cycles after grant
        ir_ready = 1'b1;
        lat      = 3;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = last_granted;
        end
        check("wait_grant_before_jump", got, 1'b1);
        jump_en   = 1'b1;
        jump_addr = 16'h0040;
        cycle();
        jump_en = 1'b0;
        base = n_pops;
        for (int i = 0; i < 30 && n_pops == base; i++) cycle();
        check("jump_first_pop_seen", n_pops > base, 1'b1);
        check("jump_first_pc", last_pop_pc, 16'h0040);

        // PC wraps from FFFF to 0000
        lat       = 1;
        jump_en   = 1'b1;
        jump_addr = 16'hFFFE;
        cycle();
        jump_en = 1'b0;
        base = n_grants;
        for (int i = 0; i < 20 && n_grants < base + 3; i++) cycle();
        check("wrap_ffff", grants[base+1], 16'hFFFF);
        check("wrap_0000", grants[base+2], 16'h0000);

        // Jump coinciding with a pop and an rvalid
        ir_ready  = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 16'h0500;
        cycle();
        jump_en = 1'b0;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = (sb_q.size() >= 1) && mem_pend && (mem_cnt == 1);
        end
        check("combo_setup", got, 1'b1);
        ir_ready  = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 16'h0600;
        base      = n_pops;
        cycle();
        jump_en = 1'b0;
        check("combo_pop_once", n_pops - base, 1);
        check("combo_pop_pc", last_pop_pc, 16'h0500);
        check("combo_rvalid_seen", last_rvalid, 1'b1);
        base = n_grants;
        cycle();
        check("combo_flushed", last_valid, 1'b0);
        for (int i = 0; i < 10 && n_grants == base; i++) cycle();
        check("combo_next_addr", grants[base], 16'h0600);

        // rvalid into an empty queue: bypass vs registered latency
        ir_ready = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = last_rvalid && last_q_empty;
        end
        check("byp_setup", got, 1'b1);
        check("byp_rv_cycle_valid", last_valid, BYP);
        cycle();
        check("byp_next_cycle_valid", last_valid, !BYP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
